// File: rtl/tree_operand_packer_pkg.sv
// ---------------------------------------------------------------------------
// tree_operand_packer_pkg : shared lane/vector types for the packer and binary_tree_adder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tree_operand_packer_pkg;

  localparam int DEFAULT_P             = 8;
  localparam int DEFAULT_INPUTS_AMOUNT = 8;

  typedef logic signed [DEFAULT_P-1:0] lane_t;
  typedef lane_t vec_t [DEFAULT_INPUTS_AMOUNT];

  // Lane count must represent INPUTS_AMOUNT itself, hence the extra bit.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tree_operand_packer_if.sv
// ---------------------------------------------------------------------------
// tree_operand_packer_if : element stream in, packed vector out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tree_operand_packer_if
  import tree_operand_packer_pkg::*;
#(
  parameter int P             = DEFAULT_P,
  parameter int INPUTS_AMOUNT = DEFAULT_INPUTS_AMOUNT
);

  localparam int CNT_W = cnt_width(INPUTS_AMOUNT);

  logic signed [P-1:0] in_data_i;
  logic                in_valid_i;
  logic                in_last_i;
  logic                in_ready_o;
  logic signed [P-1:0] vec_o [INPUTS_AMOUNT];
  logic [CNT_W-1:0]    vec_count_o;
  logic                vec_valid_o;
  logic                vec_ready_i;

  // Packer side.
  modport slave (
    input  in_data_i, in_valid_i, in_last_i, vec_ready_i,
    output in_ready_o, vec_o, vec_count_o, vec_valid_o
  );

  // Upstream producer plus downstream consumer side.
  modport master (
    output in_data_i, in_valid_i, in_last_i, vec_ready_i,
    input  in_ready_o, vec_o, vec_count_o, vec_valid_o
  );

endinterface

`default_nettype wire

// File: rtl/binary_tree_adder.sv
// ---------------------------------------------------------------------------
// binary_tree_adder : combinational pairwise-reduction sum of INPUTS_AMOUNT signed lanes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module binary_tree_adder
  import tree_operand_packer_pkg::*;
#(
  parameter  int P             = DEFAULT_P,
  parameter  int INPUTS_AMOUNT = DEFAULT_INPUTS_AMOUNT,
  localparam int LEVELS        = $clog2(INPUTS_AMOUNT),
  localparam int SUM_W         = P + LEVELS
) (
  input  logic signed [P-1:0]     lanes_i [INPUTS_AMOUNT],
  output logic signed [SUM_W-1:0] sum_o
);

  logic signed [SUM_W-1:0] partial [LEVELS+1][INPUTS_AMOUNT];

  always_comb begin
    for (int l = 0; l <= LEVELS; l++) begin
      for (int j = 0; j < INPUTS_AMOUNT; j++) begin
        partial[l][j] = '0;
      end
    end
    // Level 0 is the sign-extended inputs; each level halves the live entries.
    for (int j = 0; j < INPUTS_AMOUNT; j++) begin
      partial[0][j] = SUM_W'(lanes_i[j]);
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int j = 0; j < (INPUTS_AMOUNT >> (l + 1)); j++) begin
        partial[l+1][j] = partial[l][2*j] + partial[l][2*j+1];
      end
    end
    sum_o = partial[LEVELS][0];
  end

endmodule

`default_nettype wire

// File: rtl/tree_operand_packer.sv
// ---------------------------------------------------------------------------
// tree_operand_packer : serial-to-parallel feeder, zero-pads short vectors, double-buffered
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tree_operand_packer
  import tree_operand_packer_pkg::*;
#(
  parameter int P             = DEFAULT_P,
  parameter int INPUTS_AMOUNT = DEFAULT_INPUTS_AMOUNT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tree_operand_packer_if.slave  bus
);

  localparam int                CNT_W    = cnt_width(INPUTS_AMOUNT);
  localparam int                IDX_W    = $clog2(INPUTS_AMOUNT);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(INPUTS_AMOUNT - 1);

  logic signed [P-1:0] buf_q [INPUTS_AMOUNT];
  logic signed [P-1:0] vec_q [INPUTS_AMOUNT];
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    idx_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                pending_q;
  logic                vec_valid_q;

  logic                accept;
  logic                slot_free;
  logic                complete;
  logic                load;
  logic                drain;
  logic signed [P-1:0] load_vec [INPUTS_AMOUNT];

  always_comb begin
    accept    = bus.in_valid_i && !pending_q;
    slot_free = !vec_valid_q || bus.vec_ready_i;
    complete  = accept && ((idx_q == LAST_IDX) || bus.in_last_i);
    // complete and pending_q are exclusive: accept is blocked while pending.
    load      = (complete || pending_q) && slot_free;
    drain     = vec_valid_q && bus.vec_ready_i;
    idx_d     = idx_q + IDX_W'(1);
    cnt_d     = CNT_W'(idx_q) + CNT_W'(1);
    for (int i = 0; i < INPUTS_AMOUNT; i++) begin
      load_vec[i] = (accept && (idx_q == IDX_W'(i))) ? bus.in_data_i : buf_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < INPUTS_AMOUNT; i++) begin
        buf_q[i] <= '0;
        vec_q[i] <= '0;
      end
      idx_q       <= '0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      vec_valid_q <= 1'b0;
    end else if (load) begin
      // Buffer is cleared on every hand-off so the next short vector is zero-padded.
      for (int i = 0; i < INPUTS_AMOUNT; i++) begin
        vec_q[i] <= load_vec[i];
        buf_q[i] <= '0;
      end
      cnt_q       <= cnt_d;
      vec_valid_q <= 1'b1;
      idx_q       <= '0;
      pending_q   <= 1'b0;
    end else begin
      if (drain) begin
        vec_valid_q <= 1'b0;
      end
      if (accept) begin
        buf_q[idx_q] <= bus.in_data_i;
        // idx is frozen while pending so the count survives until hand-off.
        if (complete) begin
          pending_q <= 1'b1;
        end else begin
          idx_q <= idx_d;
        end
      end
    end
  end

  assign bus.in_ready_o  = !pending_q;
  assign bus.vec_o       = vec_q;
  assign bus.vec_count_o = cnt_q;
  assign bus.vec_valid_o = vec_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_tree_operand_packer.sv
// ---------------------------------------------------------------------------
// tb_tree_operand_packer : packer feeding binary_tree_adder, directed table + corner sequences
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tree_operand_packer;
  import tree_operand_packer_pkg::*;

  localparam int N  = 8;
  localparam int PW = 8;

  typedef struct {
    string       name;
    int          n;
    bit          fin;
    logic [63:0] el;
    logic [63:0] exp_vec;
    int          exp_cnt;
    int          exp_sum;
  } rec_t;

  typedef struct {
    int          sum;
    int          cnt;
    logic [63:0] vec;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [10:0] sum_w;
  int                 n_tests = 0;
  int                 n_fail  = 0;
  rec_t               tbl [7];
  exp_t               sb [$];

  tree_operand_packer_if #(.P(PW), .INPUTS_AMOUNT(N)) ifc ();

  tree_operand_packer #(.P(PW), .INPUTS_AMOUNT(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  binary_tree_adder #(.P(PW), .INPUTS_AMOUNT(N)) u_adder (
    .lanes_i (ifc.vec_o),
    .sum_o   (sum_w)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_vec(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] cur_vec();
    logic [63:0] r;
    for (int i = 0; i < N; i++) r[8*i +: 8] = ifc.vec_o[i];
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input bit l);
    bit done = 1'b0;
    int waitc = 0;
    ifc.in_valid_i = 1'b1;
    ifc.in_data_i  = d;
    ifc.in_last_i  = l;
    while (!done) begin
      done = ifc.in_ready_o;
      tick();
      if (!done) begin
        waitc++;
        if (waitc > 100) begin
          n_tests++;
          n_fail++;
          $display("FAIL send_timeout: in_ready_o stuck at 0 for %0d cycles, required 1", waitc);
          done = 1'b1;
        end
      end
    end
    ifc.in_valid_i = 1'b0;
    ifc.in_last_i  = 1'b0;
  endtask

  initial begin
    tbl[0] = '{name:"seq1to8",  n:8, fin:1'b0, el:64'h0807060504030201, exp_vec:64'h0807060504030201, exp_cnt:8, exp_sum:36};
    tbl[1] = '{name:"extremes", n:4, fin:1'b1, el:64'h555555550100807F, exp_vec:64'h000000000100807F, exp_cnt:4, exp_sum:0};
    tbl[2] = '{name:"single",   n:1, fin:1'b1, el:64'h55555555555555DD, exp_vec:64'h00000000000000DD, exp_cnt:1, exp_sum:-35};
    tbl[3] = '{name:"alt_last", n:8, fin:1'b1, el:64'hF807FA05FC03FE01, exp_vec:64'hF807FA05FC03FE01, exp_cnt:8, exp_sum:-4};
    tbl[4] = '{name:"all_min",  n:8, fin:1'b0, el:64'h8080808080808080, exp_vec:64'h8080808080808080, exp_cnt:8, exp_sum:-1024};
    tbl[5] = '{name:"all_max",  n:8, fin:1'b0, el:64'h7F7F7F7F7F7F7F7F, exp_vec:64'h7F7F7F7F7F7F7F7F, exp_cnt:8, exp_sum:1016};
    tbl[6] = '{name:"three",    n:3, fin:1'b1, el:64'h555555555564FF05, exp_vec:64'h000000000064FF05, exp_cnt:3, exp_sum:104};

    ifc.in_data_i   = '0;
    ifc.in_valid_i  = 1'b0;
    ifc.in_last_i   = 1'b0;
    ifc.vec_ready_i = 1'b0;
    rst_n           = 1'b0;
    repeat (2) tick();
    check_int("rst_valid", int'(ifc.vec_valid_o), 0);
    check_int("rst_count", int'(ifc.vec_count_o), 0);
    check_vec("rst_vec", cur_vec(), 64'h0);
    rst_n = 1'b1;
    tick();
    check_int("rst_ready", int'(ifc.in_ready_o), 1);

    // Directed table, downstream always ready.
    ifc.vec_ready_i = 1'b1;
    for (int t = 0; t < 7; t++) begin
      for (int e = 0; e < tbl[t].n; e++) begin
        if (e == tbl[t].n - 1) check_int({tbl[t].name, "_valid_early"}, int'(ifc.vec_valid_o), 0);
        send(tbl[t].el[8*e +: 8], (e == tbl[t].n - 1) && tbl[t].fin);
      end
      check_int({tbl[t].name, "_valid"}, int'(ifc.vec_valid_o), 1);
      check_vec({tbl[t].name, "_vec"}, cur_vec(), tbl[t].exp_vec);
      check_int({tbl[t].name, "_count"}, int'(ifc.vec_count_o), tbl[t].exp_cnt);
      check_int({tbl[t].name, "_sum"}, int'(sum_w), tbl[t].exp_sum);
      tick();
    end

    // Backpressure: first vector held, second fills buffer, then both drain in order.
    ifc.vec_ready_i = 1'b0;
    for (int e = 0; e < 8; e++) send(tbl[0].el[8*e +: 8], 1'b0);
    for (int e = 0; e < 8; e++) send(tbl[3].el[8*e +: 8], e == 7);
    check_int("hold_ready_low", int'(ifc.in_ready_o), 0);
    check_int("hold_valid", int'(ifc.vec_valid_o), 1);
    ifc.in_valid_i = 1'b1;
    ifc.in_data_i  = 8'h63;
    ifc.in_last_i  = 1'b1;
    repeat (3) tick();
    ifc.in_valid_i = 1'b0;
    ifc.in_last_i  = 1'b0;
    check_vec("hold_vec_stable", cur_vec(), tbl[0].exp_vec);
    check_int("hold_count_stable", int'(ifc.vec_count_o), 8);
    check_int("hold_sum_first", int'(sum_w), 36);
    ifc.vec_ready_i = 1'b1;
    tick();
    check_int("hold_second_valid", int'(ifc.vec_valid_o), 1);
    check_vec("hold_second_vec", cur_vec(), tbl[3].exp_vec);
    check_int("hold_second_sum", int'(sum_w), -4);
    check_int("hold_ready_back", int'(ifc.in_ready_o), 1);
    tick();
    check_int("hold_drained", int'(ifc.vec_valid_o), 0);

    // Back-to-back: three vectors streamed with no input gaps.
    begin
      int ready_low = 0;
      int nvec = 0;
      int vcyc [3];
      int vsum [3];
      for (int c = 0; c < 26; c++) begin
        if (ifc.vec_valid_o) begin
          if (nvec < 3) begin
            vcyc[nvec] = c;
            vsum[nvec] = int'(sum_w);
          end
          nvec++;
        end
        if (c < 24) begin
          if (!ifc.in_ready_o) ready_low++;
          ifc.in_valid_i = 1'b1;
          ifc.in_data_i  = 8'(c + 1);
        end else begin
          ifc.in_valid_i = 1'b0;
        end
        tick();
      end
      check_int("b2b_ready_low_cycles", ready_low, 0);
      check_int("b2b_vectors", nvec, 3);
      for (int k = 0; k < 3; k++) begin
        check_int($sformatf("b2b_cycle%0d", k), vcyc[k], 8 * (k + 1));
        check_int($sformatf("b2b_sum%0d", k), vsum[k], 36 + 64 * k);
      end
    end

    // Reset mid-vector.
    for (int e = 0; e < 3; e++) send(8'(10 * (e + 1)), 1'b0);
    rst_n = 1'b0;
    #1;
    check_int("rstmid_valid", int'(ifc.vec_valid_o), 0);
    check_vec("rstmid_vec", cur_vec(), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_int("rstmid_ready", int'(ifc.in_ready_o), 1);

    // Reset while pending.
    ifc.vec_ready_i = 1'b0;
    for (int e = 0; e < 16; e++) send(8'(e + 1), 1'b0);
    check_int("rstpend_pre_ready", int'(ifc.in_ready_o), 0);
    rst_n = 1'b0;
    #1;
    check_int("rstpend_valid", int'(ifc.vec_valid_o), 0);
    check_int("rstpend_count", int'(ifc.vec_count_o), 0);
    check_vec("rstpend_vec", cur_vec(), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ifc.vec_ready_i = 1'b1;
    repeat (3) tick();
    check_int("rstpend_no_residual", int'(ifc.vec_valid_o), 0);
    check_int("rstpend_ready", int'(ifc.in_ready_o), 1);
    for (int e = 0; e < 8; e++) send(8'(e + 1), 1'b0);
    check_int("rstpend_after_count", int'(ifc.vec_count_o), 8);
    check_int("rstpend_after_sum", int'(sum_w), 36);
    tick();

    // Random vectors with gaps and random downstream backpressure.
    fork
      begin : drv
        logic [63:0] ev;
        int          esum;
        int          len;
        bit          use_last;
        for (int v = 0; v < 50; v++) begin
          len      = $urandom_range(1, 8);
          use_last = (len < 8) || ($urandom_range(0, 1) == 1);
          ev       = '0;
          esum     = 0;
          for (int e = 0; e < len; e++) begin
            ev[8*e +: 8] = 8'($urandom_range(0, 255));
            esum += int'($signed(ev[8*e +: 8]));
          end
          sb.push_back('{sum:esum, cnt:len, vec:ev});
          for (int e = 0; e < len; e++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(ev[8*e +: 8], (e == len - 1) && use_last);
          end
        end
      end
      begin : mon
        exp_t x;
        int   got = 0;
        int   cyc = 0;
        while (got < 50 && cyc < 5000) begin
          @(negedge clk);
          cyc++;
          ifc.vec_ready_i = ($urandom_range(0, 2) != 0);
          if (ifc.vec_valid_o && ifc.vec_ready_i) begin
            if (sb.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL rand_unexpected: vector %0d delivered, none outstanding", got);
            end else begin
              x = sb.pop_front();
              check_int($sformatf("rand%0d_sum", got), int'(sum_w), x.sum);
              check_int($sformatf("rand%0d_count", got), int'(ifc.vec_count_o), x.cnt);
              check_vec($sformatf("rand%0d_vec", got), cur_vec(), x.vec);
            end
            got++;
          end
        end
        if (got < 50) begin
          n_tests++;
          n_fail++;
          $display("FAIL rand_timeout: got %0d vectors, required 50", got);
        end
      end
    join
    ifc.vec_ready_i = 1'b1;
    tick();
    check_int("rand_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
